// File: rtl/ifid_decode_buf.sv
// ifid_decode_buf: 2-entry fetch->decode buffer; each word is stored with its opcode pre-decode.
// Latency: a word pushed in cycle N appears on out_* in cycle N+1 (no bypass).
// Backpressure: in_ready = !full from registered count; a pop frees a slot from the next cycle.
module ifid_decode_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_instr_type,
    output logic            out_illegal
);

    logic [1:0]      count_q, count_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [31:0]     ir_q   [2];
    logic [31:0]     ir_d   [2];
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] pc_d   [2];
    logic [4:0]      type_q [2];
    logic [4:0]      type_d [2];
    logic            ill_q  [2];
    logic            ill_d  [2];

    logic            push;
    logic            pop;
    logic [4:0]      dec_type;
    logic            dec_ill;

    // Handshake is decoded from registered count only, so there is no in->out combinational path.
    assign in_ready       = (count_q != 2'd2);
    assign out_valid      = (count_q != 2'd0);
    assign out_ir         = ir_q[rd_q];
    assign out_pc         = pc_q[rd_q];
    assign out_instr_type = type_q[rd_q];
    assign out_illegal    = ill_q[rd_q];

    // Opcode-level decode of the incoming word; type bits are {j,u,b,s,i}.
    always_comb begin
        dec_type = 5'b00000;
        dec_ill  = 1'b0;
        case (in_ir[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111,
            7'b0001111,
            7'b1110011: dec_type = 5'b00001;
            7'b0011011: begin
                if (XLEN == 64) dec_type = 5'b00001;
                else            dec_ill  = 1'b1;
            end
            7'b0100011: dec_type = 5'b00010;
            7'b1100011: dec_type = 5'b00100;
            7'b1101111: dec_type = 5'b10000;
            7'b0110111,
            7'b0010111: dec_type = 5'b01000;
            7'b0110011: dec_ill  = 1'b0;
            7'b0111011: begin
                if (XLEN != 64) dec_ill = 1'b1;
            end
            default:    dec_ill  = 1'b1;
        endcase
    end

    always_comb begin
        push    = in_valid & in_ready;
        pop     = out_valid & out_ready;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        type_d  = type_q;
        ill_d   = ill_q;
        if (flush) begin
            // Redirect: drop everything, including a word offered this cycle.
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (push) begin
                ir_d[wr_q]   = in_ir;
                pc_d[wr_q]   = in_pc;
                type_d[wr_q] = dec_type;
                ill_d[wr_q]  = dec_ill;
                wr_d         = ~wr_q;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ir_q[i]   <= '0;
                pc_q[i]   <= '0;
                type_q[i] <= '0;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            for (int i = 0; i < 2; i++) begin
                ir_q[i]   <= ir_d[i];
                pc_q[i]   <= pc_d[i];
                type_q[i] <= type_d[i];
                ill_q[i]  <= ill_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ifid_decode_buf.sv
// Bench for ifid_decode_buf: XLEN=32 and XLEN=64 instances share stimulus and a queue-based model.
module tb_ifid_decode_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_ir32, out_pc32;
    logic [4:0]  out_type32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [31:0] out_ir64;
    logic [63:0] out_pc64;
    logic [4:0]  out_type64;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    ifid_decode_buf #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_ir(in_ir), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_ir(out_ir32), .out_pc(out_pc32),
        .out_instr_type(out_type32), .out_illegal(out_ill32)
    );

    ifid_decode_buf #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready), .out_ir(out_ir64), .out_pc(out_pc64),
        .out_instr_type(out_type64), .out_illegal(out_ill64)
    );

    // Returns {illegal, j,u,b,s,i} from the opcode table.
    function automatic logic [5:0] ref_dec(input logic [31:0] ir, input bit rv64);
        logic [6:0] op;
        op = ir[6:0];
        case (op)
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 6'b000001;
            7'h1B:        return rv64 ? 6'b000001 : 6'b100000;
            7'h23:        return 6'b000010;
            7'h63:        return 6'b000100;
            7'h6F:        return 6'b010000;
            7'h37, 7'h17: return 6'b001000;
            7'h33:        return 6'b000000;
            7'h3B:        return rv64 ? 6'b000000 : 6'b100000;
            default:      return 6'b100000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit v, input logic [31:0] ir, input logic [63:0] pc,
                       input bit ordy, input bit fl);
        in_valid  = v;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Checks outputs against the model mid-cycle, then advances model and DUT one clock.
    task automatic step();
        logic [5:0] e32, e64;
        bit         do_push, do_pop;
        @(negedge clk);
        chk("valid32", out_valid32, q.size() != 0);
        chk("ready32", in_ready32, q.size() != 2);
        chk("valid64", out_valid64, q.size() != 0);
        chk("ready64", in_ready64, q.size() != 2);
        if (q.size() != 0) begin
            e32 = ref_dec(q[0].ir, 1'b0);
            e64 = ref_dec(q[0].ir, 1'b1);
            chk("ir32", out_ir32, q[0].ir);
            chk("pc32", out_pc32, q[0].pc[31:0]);
            chk("type32", out_type32, e32[4:0]);
            chk("ill32", out_ill32, e32[5]);
            chk("ir64", out_ir64, q[0].ir);
            chk("pc64", out_pc64, q[0].pc);
            chk("type64", out_type64, e64[4:0]);
            chk("ill64", out_ill64, e64[5]);
        end
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{in_ir, in_pc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] ops [16];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h1B, 7'h23, 7'h63,
                7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h7F, 7'h01, 7'h2F};
        rst_n = 1'b0;
        drv(0, 32'h0, 64'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid32, 1'b0);
        chk("rst_ready", in_ready32, 1'b1);
        chk("rst_ir", out_ir32, 32'h0);
        chk("rst_pc", out_pc64, 64'h0);
        chk("rst_type", out_type32, 5'h0);
        chk("rst_ill", out_ill64, 1'b0);
        rst_n = 1'b1;

        // addi visible one cycle after push, gone the cycle after
        drv(1, 32'h00500093, 64'h100, 1, 0);
        step();
        drv(0, 32'h0, 64'h0, 1, 0);
        chk("addi_vld", out_valid32, 1'b1);
        chk("addi_type", out_type32, 5'b00001);
        chk("addi_pc", out_pc32, 32'h100);
        step();
        chk("addi_drained", out_valid32, 1'b0);

        // back-to-back stream s, b, j, u
        drv(1, 32'h0020A423, 64'h200, 1, 0); step();
        drv(1, 32'h00000063, 64'h204, 1, 0); step();
        drv(1, 32'h0000006F, 64'h208, 1, 0); step();
        drv(1, 32'h123450B7, 64'h20C, 1, 0); step();
        drv(0, 32'h0, 64'h0, 1, 0);          step();
        step();

        // fill with out_ready=0, third word held off, then drain
        drv(1, 32'h00000013, 64'h300, 0, 0); step();
        drv(1, 32'h00000017, 64'h304, 0, 0); step();
        drv(1, 32'h00000023, 64'h308, 0, 0);
        chk("full_ready", in_ready32, 1'b0);
        step();
        step();
        drv(1, 32'h00000023, 64'h308, 1, 0); step();
        chk("ready_after_pop", in_ready32, 1'b1);
        drv(0, 32'h0, 64'h0, 1, 0);
        repeat (4) step();

        // decode corner cases
        drv(1, 32'h002081B3, 64'h400, 1, 0); step();
        drv(1, 32'hFFFFFFFF, 64'h404, 1, 0);
        chk("add_type", out_type32, 5'b0);
        chk("add_ill", out_ill32, 1'b0);
        step();
        drv(1, 32'h0000001B, 64'h408, 1, 0);
        chk("ffff_ill", out_ill32, 1'b1);
        step();
        drv(0, 32'h0, 64'h0, 1, 0);
        chk("opimm32_ill32", out_ill32, 1'b1);
        chk("opimm32_type64", out_type64, 5'b00001);
        chk("opimm32_ill64", out_ill64, 1'b0);
        step();

        // flush at count=2 with a word offered
        drv(1, 32'h00000003, 64'h500, 0, 0); step();
        drv(1, 32'h00000033, 64'h504, 0, 0); step();
        drv(1, 32'h0000006F, 64'h508, 0, 1); step();
        drv(0, 32'h0, 64'h0, 1, 0);
        chk("flush_vld", out_valid32, 1'b0);
        chk("flush_rdy", in_ready32, 1'b1);
        step();
        // flush overrides a push that would otherwise be accepted
        drv(1, 32'h00000013, 64'h600, 1, 1); step();
        drv(0, 32'h0, 64'h0, 1, 0);
        chk("flush_drop", out_valid64, 1'b0);
        step();

        // async reset pulse while count=1
        drv(1, 32'h00000073, 64'h700, 0, 0); step();
        drv(0, 32'h0, 64'h0, 0, 0);
        chk("pre_rst_vld", out_valid32, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("arst_vld", out_valid32, 1'b0);
        chk("arst_rdy", in_ready32, 1'b1);
        chk("arst_vld64", out_valid64, 1'b0);
        q.delete();
        #1;
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 1) r[6:0] = ops[$urandom_range(15, 0)];
            drv(($urandom % 4) != 0, r, {$urandom, $urandom},
                ($urandom % 3) != 0, ($urandom % 20) == 0);
            step();
        end
        drv(0, 32'h0, 64'h0, 1, 0);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
